// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, field widths, the score
// drawer's state type and binary-to-BCD helpers for 0..31 scores.
package pong_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int COLOUR_W    = 3;
  localparam int SCORE_W     = 5;
  localparam int DIGIT_W     = 3;
  localparam int DIGIT_H     = 5;
  localparam int DIGIT_PITCH = 4;
  localparam int GLYPH_BITS  = DIGIT_W * DIGIT_H;

  typedef enum logic [1:0] {
    SD_IDLE = 2'd0,
    SD_LOAD = 2'd1,
    SD_DRAW = 2'd2,
    SD_DONE = 2'd3
  } sd_state_t;

  // Tens digit of a 0..31 score.
  function automatic logic [1:0] bcd_tens(input logic [SCORE_W-1:0] s);
    logic [1:0] t;
    if (s >= 5'd30) begin
      t = 2'd3;
    end else if (s >= 5'd20) begin
      t = 2'd2;
    end else if (s >= 5'd10) begin
      t = 2'd1;
    end else begin
      t = 2'd0;
    end
    return t;
  endfunction

  // Ones digit of a 0..31 score. The result is always 0..9, so it is
  // enough to subtract 10*tens modulo 16 from the low nibble.
  function automatic logic [3:0] bcd_ones(input logic [SCORE_W-1:0] s);
    logic [3:0] sub;
    case (bcd_tens(s))
      2'd0:    sub = 4'd0;
      2'd1:    sub = 4'd10;
      2'd2:    sub = 4'd4;   // 20 mod 16
      2'd3:    sub = 4'd14;  // 30 mod 16
      default: sub = 4'd0;
    endcase
    return s[3:0] - sub;
  endfunction

endpackage

// File: rtl/digit_font.sv
// 3x5 decimal glyph ROM. Bit 14-(row*3+col) is the pixel, MSB = top-left.
// Codes 10..15 have no glyph and return all zeros.
module digit_font
  import pong_pkg::*;
(
  input  logic [3:0]            digit,
  output logic [GLYPH_BITS-1:0] glyph
);

  // Glyph lookup, rows listed top to bottom in groups of three bits.
  always_comb begin
    glyph = 15'b000_000_000_000_000;
    case (digit)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b010_110_010_010_111;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      default: glyph = 15'b000_000_000_000_000;
    endcase
  end

endmodule

// File: rtl/score_drawer.sv
// Draws both Pong scores as four 3x5 digit cells, one pixel per cycle,
// as a plot stream for vga_adapter. Every cell pixel is written so stale
// digits are erased; a zero tens digit is drawn entirely in background.
module score_drawer
  import pong_pkg::*;
#(
  parameter int                  LEFT_X    = 60,
  parameter int                  RIGHT_X   = 96,
  parameter int                  TOP_Y     = 2,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [SCORE_W-1:0]  left_score,
  input  logic [SCORE_W-1:0]  right_score,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  localparam logic [7:0] ORG0  = 8'(LEFT_X);
  localparam logic [7:0] ORG1  = 8'(LEFT_X + DIGIT_PITCH);
  localparam logic [7:0] ORG2  = 8'(RIGHT_X);
  localparam logic [7:0] ORG3  = 8'(RIGHT_X + DIGIT_PITCH);
  localparam logic [6:0] ORG_Y = 7'(TOP_Y);
  localparam logic [2:0] LAST_ROW = 3'(DIGIT_H - 1);
  localparam logic [1:0] LAST_COL = 2'(DIGIT_W - 1);

  sd_state_t state, state_next;

  logic [SCORE_W-1:0] left_lat, right_lat;
  logic               latch_en;

  logic [1:0] digit_cnt, digit_next;
  logic [2:0] row_cnt, row_next;
  logic [1:0] col_cnt, col_next;

  logic plot_next, done_next;

  // BCD split of the latched scores; settles during the LOAD cycle.
  logic [1:0] left_tens, right_tens;
  logic [3:0] left_ones, right_ones;
  assign left_tens  = bcd_tens(left_lat);
  assign left_ones  = bcd_ones(left_lat);
  assign right_tens = bcd_tens(right_lat);
  assign right_ones = bcd_ones(right_lat);

  logic [3:0]            cell_val;
  logic                  cell_blank;
  logic [7:0]            cell_org;
  logic [GLYPH_BITS-1:0] glyph;
  logic [3:0]            pix_idx;
  logic                  pix_lit;
  logic [7:0]            pix_x;
  logic [6:0]            pix_y;
  logic [COLOUR_W-1:0]   pix_colour;

  digit_font u_font (
    .digit (cell_val),
    .glyph (glyph)
  );

  // Select the digit value, blanking and origin for the pixel being issued.
  always_comb begin
    cell_val   = 4'd0;
    cell_blank = 1'b0;
    cell_org   = ORG0;
    case (digit_next)
      2'd0: begin
        cell_val   = {2'b00, left_tens};
        cell_blank = (left_tens == 2'd0);
        cell_org   = ORG0;
      end
      2'd1: begin
        cell_val   = left_ones;
        cell_blank = 1'b0;
        cell_org   = ORG1;
      end
      2'd2: begin
        cell_val   = {2'b00, right_tens};
        cell_blank = (right_tens == 2'd0);
        cell_org   = ORG2;
      end
      2'd3: begin
        cell_val   = right_ones;
        cell_blank = 1'b0;
        cell_org   = ORG3;
      end
      default: begin
        cell_val   = 4'd0;
        cell_blank = 1'b1;
        cell_org   = ORG0;
      end
    endcase
  end

  // Pixel position and colour for the next counter position.
  always_comb begin
    pix_idx    = ({1'b0, row_next} * 4'd3) + {2'b00, col_next};
    pix_lit    = glyph[4'd14 - pix_idx] & ~cell_blank;
    pix_x      = cell_org + {6'd0, col_next};
    pix_y      = ORG_Y + {4'd0, row_next};
    pix_colour = pix_lit ? FG_COLOUR : BG_COLOUR;
  end

  // Next state, scan counter advance and plot/done strobes.
  always_comb begin
    state_next = state;
    digit_next = digit_cnt;
    row_next   = row_cnt;
    col_next   = col_cnt;
    plot_next  = 1'b0;
    done_next  = 1'b0;
    latch_en   = 1'b0;
    case (state)
      SD_IDLE: begin
        digit_next = 2'd0;
        row_next   = 3'd0;
        col_next   = 2'd0;
        if (start) begin
          latch_en   = 1'b1;
          state_next = SD_LOAD;
        end else begin
          state_next = SD_IDLE;
        end
      end
      SD_LOAD: begin
        // First pixel is issued from cleared counters at the end of LOAD.
        digit_next = 2'd0;
        row_next   = 3'd0;
        col_next   = 2'd0;
        plot_next  = 1'b1;
        state_next = SD_DRAW;
      end
      SD_DRAW: begin
        if ((digit_cnt == 2'd3) && (row_cnt == LAST_ROW) && (col_cnt == LAST_COL)) begin
          done_next  = 1'b1;
          state_next = SD_DONE;
        end else begin
          plot_next = 1'b1;
          if (col_cnt != LAST_COL) begin
            col_next = col_cnt + 2'd1;
          end else if (row_cnt != LAST_ROW) begin
            col_next = 2'd0;
            row_next = row_cnt + 3'd1;
          end else begin
            col_next   = 2'd0;
            row_next   = 3'd0;
            digit_next = digit_cnt + 2'd1;
          end
        end
      end
      SD_DONE: begin
        state_next = SD_IDLE;
      end
      default: begin
        state_next = SD_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= SD_IDLE;
      digit_cnt <= 2'd0;
      row_cnt   <= 3'd0;
      col_cnt   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= BG_COLOUR;
    end else begin
      state     <= state_next;
      digit_cnt <= digit_next;
      row_cnt   <= row_next;
      col_cnt   <= col_next;
      busy      <= (state_next != SD_IDLE);
      done      <= done_next;
      plot      <= plot_next;
      if (plot_next) begin
        x      <= pix_x;
        y      <= pix_y;
        colour <= pix_colour;
      end
    end
  end

  // Score capture on an accepted start; held for the whole pass.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      left_lat  <= 5'd0;
      right_lat <= 5'd0;
    end else if (latch_en) begin
      left_lat  <= left_score;
      right_lat <= right_score;
    end
  end

endmodule
